irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- CPU-side responder for the interrupt controller peripheral: consumes irq_req / irq_number and produces ack_attended / ack_complete.
- Waits for an instruction boundary, saves the PC, redirects fetch to a vector, and restores the PC on RETI.
- Sits between the interrupt controller outputs and the VeSPA core fetch unit.
- Carries a small memory-mapped register bank (global enable, vector base, saved PC) on the standard peripheral bus.

Parameters:
- VBASE_RESET, 32'h0000_0010, reset value of the vector base register (bits [1:0] forced 0).
- VEC_SHIFT, 2, log2 of vector stride in bytes; vector = VBASE + (irq_number << VEC_SHIFT).

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  reset, synchronous, active-high.
- i_WEnable  in  1  bus write strobe.
- i_WAddr  in  32  bus write address (register index).
- i_WData  in  32  bus write data.
- i_REnable  in  1  bus read strobe.
- i_RAddr  in  32  bus read address.
- o_RData  out  32  registered read data.
- o_Err  out  1  registered bus error flag.
- i_IrqReq  in  1  interrupt request from controller.
- i_IrqNumber  in  2  requesting source index.
- i_InstrBoundary  in  1  core at an instruction boundary; safe to redirect.
- i_CurPc  in  32  PC of the next instruction to execute.
- i_Reti  in  1  one-cycle pulse, core executed RETI.
- o_AckAttended  out  1  one-cycle pulse, interrupt taken.
- o_AckComplete  out  1  one-cycle pulse, ISR finished.
- o_StallCpu  out  1  core must hold fetch.
- o_PcLoad  out  1  one-cycle pulse, core loads o_PcValue into PC.
- o_PcValue  out  32  PC redirect value.
- o_InService  out  1  ISR in progress.

Behaviour:
- Register map (index = full address; any other address sets o_Err = 1):
  - 0 CTRL: bit0 = GIE, R/W; other bits read 0.
  - 1 VBASE: R/W; bits [1:0] written as 0.
  - 2 SAVED_PC: read-only; a write sets o_Err = 1 and does not change it.
- Bus rules:
  - Write has priority over read in the same cycle.
  - o_Err and o_RData update only on an access; a valid access clears o_Err.
  - Both hold their value when there is no access.
  - Read data appears the cycle after the strobe.
- Reset: state IDLE; GIE=0; VBASE=VBASE_RESET; SAVED_PC=0; o_RData=0; o_Err=0. All pulses, o_StallCpu, o_PcLoad, o_PcValue, o_InService are 0.
- Outputs are registered (Moore on state).
- FSM:
  - IDLE: i_IrqReq & GIE -> WAIT_BND. i_Reti ignored.
  - WAIT_BND:
    - If i_IrqReq=0 or GIE=0, return to IDLE with no ack.
    - Else if i_InstrBoundary=1, go to SAVE; on that edge latch SAVED_PC <= i_CurPc and num <= i_IrqNumber.
  - SAVE: o_StallCpu=1. Compute vector from the current VBASE; a same-cycle bus write takes effect only afterwards. Go to VECTOR.
  - VECTOR: o_StallCpu=1, o_PcLoad=1, o_PcValue=vector, o_AckAttended=1, o_InService=1. Next state IN_SVC.
  - IN_SVC: o_InService=1. i_IrqReq ignored (no nesting). i_Reti -> RETURN.
  - RETURN: o_StallCpu=1, o_PcLoad=1, o_PcValue=SAVED_PC, o_AckComplete=1, o_InService=1. Next state IDLE.
    - If i_IrqReq is still high, the next request is re-evaluated from IDLE one cycle later.
- Vector arithmetic: 32-bit add of VBASE + (num << VEC_SHIFT); wraps modulo 2^32.
- Latency: irq_req rise in IDLE with boundary held high gives o_AckAttended 3 cycles later (IDLE->WAIT_BND->SAVE->VECTOR).
- GIE write to 0 while in IN_SVC does not abort service.
- Reset mid-operation: immediate return to IDLE with no ack pulses; SAVED_PC cleared.

Optional Feature:
- IRQ_LATENCY_CNT_EN
  - Defined:
    - Register index 3 LATENCY, read-only (write -> o_Err).
    - 16-bit counter cleared on IDLE->WAIT_BND, incrementing each cycle in WAIT_BND/SAVE, frozen at VECTOR, saturating at 16'hFFFF.
    - Reads return zero-extended.
  - Undefined: index 3 is an invalid address (o_Err=1); no counter logic.

Test Plan:
- Reset, then read addresses 0/1/2 -> 0, 32'h10, 0; o_Err=0. Read address 5 -> o_Err=1.
- GIE=1, VBASE=32'h100, irq_num=2, boundary held 1, i_CurPc=32'h40 -> o_AckAttended pulse 3 cycles after req; o_PcLoad with o_PcValue=32'h108; SAVED_PC reads 32'h40.
- In IN_SVC, pulse i_Reti -> next cycle o_AckComplete=1, o_PcLoad=1, o_PcValue=32'h40; following cycle o_InService=0, state IDLE.
- Req with GIE=1, boundary=0 for 5 cycles, then req drops -> no ack, back to IDLE. Repeat with GIE=0 -> WAIT_BND never entered.
- Assert i_Rst while in IN_SVC -> next cycle all outputs 0, GIE=0; a subsequent i_Reti produces no o_AckComplete.
- With IRQ_LATENCY_CNT_EN: boundary asserted 4 cycles after entering WAIT_BND -> LATENCY reads 6. Writing index 2 or 3 -> o_Err=1, values unchanged.

Source files
------------

// File: rtl/irq_sequencer_if.sv
// rtl/irq_sequencer_if.sv - register bus, interrupt controller and core fetch signals of irq_sequencer
interface irq_sequencer_if;
  // Peripheral register bus
  logic        i_WEnable;
  logic [31:0] i_WAddr;
  logic [31:0] i_WData;
  logic        i_REnable;
  logic [31:0] i_RAddr;
  logic [31:0] o_RData;
  logic        o_Err;
  // Interrupt controller side
  logic        i_IrqReq;
  logic [1:0]  i_IrqNumber;
  logic        o_AckAttended;
  logic        o_AckComplete;
  // Core fetch side
  logic        i_InstrBoundary;
  logic [31:0] i_CurPc;
  logic        i_Reti;
  logic        o_StallCpu;
  logic        o_PcLoad;
  logic [31:0] o_PcValue;
  logic        o_InService;

  modport slave (
    input  i_WEnable, i_WAddr, i_WData, i_REnable, i_RAddr,
    input  i_IrqReq, i_IrqNumber, i_InstrBoundary, i_CurPc, i_Reti,
    output o_RData, o_Err, o_AckAttended, o_AckComplete,
    output o_StallCpu, o_PcLoad, o_PcValue, o_InService
  );

  modport master (
    output i_WEnable, i_WAddr, i_WData, i_REnable, i_RAddr,
    output i_IrqReq, i_IrqNumber, i_InstrBoundary, i_CurPc, i_Reti,
    input  o_RData, o_Err, o_AckAttended, o_AckComplete,
    input  o_StallCpu, o_PcLoad, o_PcValue, o_InService
  );
endinterface

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt entry/return sequencer with GIE/VBASE/SAVED_PC registers; optional IRQ_LATENCY_CNT_EN adds LATENCY register
module irq_sequencer #(
  parameter logic [31:0] VBASE_RESET = 32'h0000_0010,
  parameter int          VEC_SHIFT   = 2
) (
  input logic            i_Clk,
  input logic            i_Rst,
  irq_sequencer_if.slave bus
);

  localparam logic [31:0] VBASE_INIT = VBASE_RESET & 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BND,
    ST_SAVE,
    ST_VECTOR,
    ST_IN_SVC,
    ST_RETURN
  } state_t;

  state_t      state_q, state_d;
  logic        gie_q;
  logic [31:0] vbase_q;
  logic [31:0] saved_pc_q;
  logic [1:0]  num_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        ack_att_q, ack_att_d;
  logic        ack_cmp_q, ack_cmp_d;
  logic        stall_q, stall_d;
  logic        pc_load_q, pc_load_d;
  logic [31:0] pc_value_q, pc_value_d;
  logic        in_svc_q, in_svc_d;

  logic [31:0] vec_offset;
  logic        rd_valid;
  logic [31:0] rd_value;

  assign vec_offset = {30'd0, num_q} << VEC_SHIFT;

`ifdef IRQ_LATENCY_CNT_EN
  logic [15:0] lat_q;

  // Entry latency: restart when a request is accepted, count WAIT_BND/SAVE cycles, saturate
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      lat_q <= 16'd0;
    end else if (state_q == ST_IDLE && state_d == ST_WAIT_BND) begin
      lat_q <= 16'd0;
    end else if ((state_q == ST_WAIT_BND || state_q == ST_SAVE) && lat_q != 16'hFFFF) begin
      lat_q <= lat_q + 16'd1;
    end
  end
`endif

  // Next state, then outputs decoded from the next state so they leave a register
  always_comb begin
    state_d    = state_q;
    ack_att_d  = 1'b0;
    ack_cmp_d  = 1'b0;
    stall_d    = 1'b0;
    pc_load_d  = 1'b0;
    pc_value_d = 32'd0;
    in_svc_d   = 1'b0;
    case (state_q)
      ST_IDLE:     if (bus.i_IrqReq && gie_q) state_d = ST_WAIT_BND;
      ST_WAIT_BND: begin
        if (!bus.i_IrqReq || !gie_q)    state_d = ST_IDLE;
        else if (bus.i_InstrBoundary)   state_d = ST_SAVE;
      end
      ST_SAVE:     state_d = ST_VECTOR;
      ST_VECTOR:   state_d = ST_IN_SVC;
      ST_IN_SVC:   if (bus.i_Reti) state_d = ST_RETURN;
      ST_RETURN:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_SAVE: stall_d = 1'b1;
      ST_VECTOR: begin
        // vbase_q here is the value during SAVE; a write in that cycle lands afterwards
        stall_d    = 1'b1;
        pc_load_d  = 1'b1;
        pc_value_d = vbase_q + vec_offset;
        ack_att_d  = 1'b1;
        in_svc_d   = 1'b1;
      end
      ST_IN_SVC: in_svc_d = 1'b1;
      ST_RETURN: begin
        stall_d    = 1'b1;
        pc_load_d  = 1'b1;
        pc_value_d = saved_pc_q;
        ack_cmp_d  = 1'b1;
        in_svc_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State and registered core/controller outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      ack_att_q  <= 1'b0;
      ack_cmp_q  <= 1'b0;
      stall_q    <= 1'b0;
      pc_load_q  <= 1'b0;
      pc_value_q <= 32'd0;
      in_svc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_att_q  <= ack_att_d;
      ack_cmp_q  <= ack_cmp_d;
      stall_q    <= stall_d;
      pc_load_q  <= pc_load_d;
      pc_value_q <= pc_value_d;
      in_svc_q   <= in_svc_d;
    end
  end

  // Capture return PC and source index as the core is redirected
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      saved_pc_q <= 32'd0;
      num_q      <= 2'd0;
    end else if (state_q == ST_WAIT_BND && state_d == ST_SAVE) begin
      saved_pc_q <= bus.i_CurPc;
      num_q      <= bus.i_IrqNumber;
    end
  end

  // Read decode; unmapped indices flag an error
  always_comb begin
    rd_valid = 1'b1;
    rd_value = 32'd0;
    case (bus.i_RAddr)
      32'd0:   rd_value = {31'd0, gie_q};
      32'd1:   rd_value = vbase_q;
      32'd2:   rd_value = saved_pc_q;
`ifdef IRQ_LATENCY_CNT_EN
      32'd3:   rd_value = {16'd0, lat_q};
`endif
      default: rd_valid = 1'b0;
    endcase
  end

  // Register bank; write wins over a same-cycle read, rdata/err hold when idle
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      gie_q   <= 1'b0;
      vbase_q <= VBASE_INIT;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (bus.i_WEnable) begin
      if (bus.i_WAddr == 32'd0) begin
        gie_q <= bus.i_WData[0];
        err_q <= 1'b0;
      end else if (bus.i_WAddr == 32'd1) begin
        vbase_q <= bus.i_WData & 32'hFFFF_FFFC;
        err_q   <= 1'b0;
      end else begin
        err_q <= 1'b1;
      end
    end else if (bus.i_REnable) begin
      if (rd_valid) begin
        rdata_q <= rd_value;
        err_q   <= 1'b0;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.o_RData       = rdata_q;
  assign bus.o_Err         = err_q;
  assign bus.o_AckAttended = ack_att_q;
  assign bus.o_AckComplete = ack_cmp_q;
  assign bus.o_StallCpu    = stall_q;
  assign bus.o_PcLoad      = pc_load_q;
  assign bus.o_PcValue     = pc_value_q;
  assign bus.o_InService   = in_svc_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - directed bench for irq_sequencer: register table plus interrupt entry/return sequences
module tb_irq_sequencer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  irq_sequencer_if bus_if();

  irq_sequencer dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] raddr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } bus_vec_t;

  bus_vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.i_WEnable = 1'b1;
    bus_if.i_WAddr   = a;
    bus_if.i_WData   = d;
    tick();
    bus_if.i_WEnable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    bus_if.i_REnable = 1'b1;
    bus_if.i_RAddr   = a;
    tick();
    bus_if.i_REnable = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {26'd0, bus_if.o_AckAttended, bus_if.o_AckComplete, bus_if.o_StallCpu,
            bus_if.o_PcLoad, bus_if.o_InService, bus_if.o_Err};
  endfunction

  initial begin
    errors = 0;
    checks = 0;

    vecs[0]  = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd0, 1'b1, 32'h0,   1'b0};
    vecs[1]  = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd1, 1'b1, 32'h10,  1'b0};
    vecs[2]  = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd2, 1'b1, 32'h0,   1'b0};
    vecs[3]  = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd5, 1'b0, 32'h0,   1'b1};
    vecs[4]  = '{1'b1, 32'd1, 32'h103,       1'b0, 32'd0, 1'b0, 32'h0,   1'b0};
    vecs[5]  = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd1, 1'b1, 32'h100, 1'b0};
    vecs[6]  = '{1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 32'h0,   1'b0};
    vecs[7]  = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd0, 1'b1, 32'h1,   1'b0};
    vecs[8]  = '{1'b1, 32'd2, 32'h55,        1'b0, 32'd0, 1'b0, 32'h0,   1'b1};
    vecs[9]  = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd2, 1'b1, 32'h0,   1'b0};
    vecs[10] = '{1'b1, 32'd3, 32'h7,         1'b0, 32'd0, 1'b0, 32'h0,   1'b1};
`ifdef IRQ_LATENCY_CNT_EN
    vecs[11] = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd3, 1'b1, 32'h0,   1'b0};
`else
    vecs[11] = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd3, 1'b0, 32'h0,   1'b1};
`endif
    vecs[12] = '{1'b1, 32'd0, 32'h0,         1'b1, 32'd1, 1'b0, 32'h0,   1'b0};
    vecs[13] = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd0, 1'b1, 32'h0,   1'b0};
    vecs[14] = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd7, 1'b0, 32'h0,   1'b1};
    vecs[15] = '{1'b0, 32'd0, 32'd0,         1'b0, 32'd0, 1'b1, 32'h0,   1'b1};
    vecs[16] = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd0, 1'b1, 32'h0,   1'b0};
    vecs[17] = '{1'b1, 32'd0, 32'h1,         1'b0, 32'd0, 1'b0, 32'h0,   1'b0};
    vecs[18] = '{1'b0, 32'd0, 32'd0,         1'b1, 32'd0, 1'b1, 32'h1,   1'b0};

    rst                    = 1'b1;
    bus_if.i_WEnable       = 1'b0;
    bus_if.i_WAddr         = 32'd0;
    bus_if.i_WData         = 32'd0;
    bus_if.i_REnable       = 1'b0;
    bus_if.i_RAddr         = 32'd0;
    bus_if.i_IrqReq        = 1'b0;
    bus_if.i_IrqNumber     = 2'd0;
    bus_if.i_InstrBoundary = 1'b0;
    bus_if.i_CurPc         = 32'd0;
    bus_if.i_Reti          = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outs", outs(), 32'd0);
    chk("reset_pcvalue", bus_if.o_PcValue, 32'd0);
    chk("reset_rdata", bus_if.o_RData, 32'd0);

    // Register bank table
    for (int i = 0; i < 19; i++) begin
      bus_if.i_WEnable = vecs[i].we;
      bus_if.i_WAddr   = vecs[i].waddr;
      bus_if.i_WData   = vecs[i].wdata;
      bus_if.i_REnable = vecs[i].re;
      bus_if.i_RAddr   = vecs[i].raddr;
      tick();
      bus_if.i_WEnable = 1'b0;
      bus_if.i_REnable = 1'b0;
      chk($sformatf("vec%0d_err", i), {31'd0, bus_if.o_Err}, {31'd0, vecs[i].exp_err});
      if (vecs[i].chk_rd)
        chk($sformatf("vec%0d_rdata", i), bus_if.o_RData, vecs[i].exp_rd);
    end

    // A: GIE=1, VBASE=0x100, irq 2, boundary held
    bus_if.i_IrqReq        = 1'b1;
    bus_if.i_IrqNumber     = 2'd2;
    bus_if.i_InstrBoundary = 1'b1;
    bus_if.i_CurPc         = 32'h40;
    tick();
    chk("A_wait_outs", outs(), 32'd0);
    tick();
    chk("A_save_outs", outs(), 32'b001000);
    tick();
    chk("A_vector_outs", outs(), 32'b101110);
    chk("A_vector_pc", bus_if.o_PcValue, 32'h108);
    bus_if.i_IrqReq = 1'b0;
    tick();
    chk("A_insvc_outs", outs(), 32'b000010);
    bus_write(32'd0, 32'd0);
    chk("A_gie_off_keeps_svc", outs(), 32'b000010);
    bus_read(32'd2);
    chk("A_saved_pc", bus_if.o_RData, 32'h40);
`ifdef IRQ_LATENCY_CNT_EN
    bus_read(32'd3);
    chk("A_latency", bus_if.o_RData, 32'd2);
`endif
    bus_if.i_Reti = 1'b1;
    tick();
    bus_if.i_Reti = 1'b0;
    chk("A_return_outs", outs(), 32'b011110);
    chk("A_return_pc", bus_if.o_PcValue, 32'h40);
    tick();
    chk("A_idle_outs", outs(), 32'd0);
    chk("A_idle_pc", bus_if.o_PcValue, 32'd0);

    // B: GIE=0 -> request ignored
    bus_if.i_IrqReq        = 1'b1;
    bus_if.i_IrqNumber     = 2'd1;
    bus_if.i_InstrBoundary = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("B_gie0_c%0d", i), outs(), 32'd0);
    end
    bus_if.i_IrqReq = 1'b0;

    // C: no boundary, request withdrawn, then a clean entry from IDLE
    bus_write(32'd0, 32'd1);
    bus_if.i_IrqReq        = 1'b1;
    bus_if.i_InstrBoundary = 1'b0;
    bus_if.i_CurPc         = 32'h80;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("C_nobnd_c%0d", i), outs(), 32'd0);
    end
    bus_if.i_IrqReq = 1'b0;
    tick();
    tick();
    chk("C_dropped_outs", outs(), 32'd0);
    bus_if.i_IrqReq        = 1'b1;
    bus_if.i_InstrBoundary = 1'b1;
    tick();
    chk("C_wait_outs", outs(), 32'd0);
    tick();
    chk("C_save_outs", outs(), 32'b001000);
    tick();
    chk("C_vector_outs", outs(), 32'b101110);
    chk("C_vector_pc", bus_if.o_PcValue, 32'h104);
    tick();
    chk("C_insvc_outs", outs(), 32'b000010);
    tick();
    chk("C_no_nesting", outs(), 32'b000010);
    bus_if.i_IrqNumber = 2'd3;
    bus_if.i_Reti      = 1'b1;
    tick();
    bus_if.i_Reti = 1'b0;
    chk("C_return_outs", outs(), 32'b011110);
    chk("C_return_pc", bus_if.o_PcValue, 32'h80);
    tick();
    chk("C_idle_outs", outs(), 32'd0);
    bus_if.i_CurPc = 32'hC0;
    tick();
    chk("C_rewait_outs", outs(), 32'd0);
    tick();
    chk("C_resave_outs", outs(), 32'b001000);
    bus_write(32'd1, 32'h200);
    chk("C_vbase_write_late", bus_if.o_PcValue, 32'h10C);
    chk("C_revector_outs", outs(), 32'b101110);
    bus_if.i_IrqReq = 1'b0;
    tick();
    bus_read(32'd1);
    chk("C_vbase_after", bus_if.o_RData, 32'h200);
    bus_read(32'd2);
    chk("C_saved_pc", bus_if.o_RData, 32'hC0);

    // Reset while in service
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("R_outs", outs(), 32'd0);
    chk("R_pcvalue", bus_if.o_PcValue, 32'd0);
    chk("R_rdata", bus_if.o_RData, 32'd0);
    bus_read(32'd0);
    chk("R_gie", bus_if.o_RData, 32'd0);
    bus_read(32'd2);
    chk("R_saved_pc", bus_if.o_RData, 32'd0);
    bus_if.i_Reti = 1'b1;
    tick();
    bus_if.i_Reti = 1'b0;
    chk("R_reti_ignored", outs(), 32'd0);
    tick();
    chk("R_reti_ignored2", outs(), 32'd0);

`ifdef IRQ_LATENCY_CNT_EN
    // D: boundary 4 cycles after entering WAIT_BND
    bus_write(32'd0, 32'd1);
    bus_if.i_IrqReq        = 1'b1;
    bus_if.i_InstrBoundary = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    bus_if.i_InstrBoundary = 1'b1;
    tick();
    tick();
    chk("D_vector_outs", outs(), 32'b101110);
    bus_if.i_IrqReq = 1'b0;
    tick();
    bus_read(32'd3);
    chk("D_latency", bus_if.o_RData, 32'd6);
    bus_write(32'd3, 32'h9);
    chk("D_wr3_err", {31'd0, bus_if.o_Err}, 32'd1);
    bus_write(32'd2, 32'h1);
    chk("D_wr2_err", {31'd0, bus_if.o_Err}, 32'd1);
    bus_read(32'd3);
    chk("D_latency_kept", bus_if.o_RData, 32'd6);
    bus_read(32'd2);
    chk("D_saved_pc_kept", bus_if.o_RData, 32'hC0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
